// File: rtl/raizing_textmix_pal.sv
// Purpose: merge the extra-text pixel with the resolved BG/sprite pixel, look it up in palette RAM and expand xBGR555 to RGB888.
// Latency: a pixel sampled at PIXEL_CEN n appears on RED/GREEN/BLUE/HB_OUT/VB_OUT after PIXEL_CEN n+1; RAM_LAT CLK96 cycles of RAM wait.
// Backpressure: none; if palette data has not been captured by the next PIXEL_CEN, the last word is reused and PAL_LATE sticks.
// Ports: CLK96/RESET96_N clock and async reset; PIXEL_CEN pixel enable; HB/VB/TEXT_EN/EXTRATEXT_PIXEL/LAYER_PIXEL pixel inputs;
//        PALRAM_ADDR/PALRAM_DATA palette RAM port; RED/GREEN/BLUE/HB_OUT/VB_OUT colour outputs; PAL_LATE sticky late flag.
module raizing_textmix_pal #(
    parameter int          RAM_LAT  = 2,
    parameter logic [10:0] BACKDROP = 11'd0
) (
    input  logic        CLK96,
    input  logic        RESET96_N,
    input  logic        PIXEL_CEN,
    input  logic        HB,
    input  logic        VB,
    input  logic        TEXT_EN,
    input  logic [10:0] EXTRATEXT_PIXEL,
    input  logic [10:0] LAYER_PIXEL,
    output logic [10:0] PALRAM_ADDR,
    input  logic [15:0] PALRAM_DATA,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE,
    output logic        HB_OUT,
    output logic        VB_OUT,
    output logic        PAL_LATE
);

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT);

    logic [2:0]  lat_cnt;
    logic [15:0] cap_word;
    logic        cap_vld;
    logic        hb_a;
    logic        vb_a;
    logic        primed;     // a pixel has been selected since reset, so stage B has real work

    logic [10:0] sel_addr;
    logic        cap_now;
    logic [15:0] out_word;
    logic        word_ok;

    always_comb begin
        sel_addr = BACKDROP;
        if (TEXT_EN && (EXTRATEXT_PIXEL[3:0] != 4'd0)) begin
            sel_addr = EXTRATEXT_PIXEL;
        end else if (LAYER_PIXEL[3:0] != 4'd0) begin
            sel_addr = LAYER_PIXEL;
        end
    end

    // The capture cycle can coincide with a CEN when RAM_LAT=1 and CEN is
    // continuous; forward the RAM word straight to stage B in that case.
    assign cap_now  = (lat_cnt == 3'd1);
    assign out_word = cap_now ? PALRAM_DATA : cap_word;
    assign word_ok  = cap_vld | cap_now;

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            PALRAM_ADDR <= BACKDROP;
            RED         <= 8'd0;
            GREEN       <= 8'd0;
            BLUE        <= 8'd0;
            HB_OUT      <= 1'b1;
            VB_OUT      <= 1'b1;
            PAL_LATE    <= 1'b0;
            lat_cnt     <= 3'd0;
            cap_word    <= 16'd0;
            cap_vld     <= 1'b0;
            hb_a        <= 1'b1;
            vb_a        <= 1'b1;
            primed      <= 1'b0;
        end else begin
            // RAM wait runs every CLK96, independent of the pixel enable.
            if (lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (cap_now) begin
                cap_word <= PALRAM_DATA;
                cap_vld  <= 1'b1;
            end

            if (PIXEL_CEN) begin
                // Stage B: output the pixel selected at the previous CEN.
                HB_OUT <= hb_a;
                VB_OUT <= vb_a;
                if (hb_a || vb_a) begin
                    RED   <= 8'd0;
                    GREEN <= 8'd0;
                    BLUE  <= 8'd0;
                end else begin
                    RED   <= {out_word[4:0],   out_word[4:2]};
                    GREEN <= {out_word[9:5],   out_word[9:7]};
                    BLUE  <= {out_word[14:10], out_word[14:12]};
                end
                if (primed && !word_ok) begin
                    PAL_LATE <= 1'b1;
                end

                // Stage A: select the new pixel and restart the RAM wait.
                PALRAM_ADDR <= sel_addr;
                hb_a        <= HB;
                vb_a        <= VB;
                lat_cnt     <= LAT_LOAD;
                cap_vld     <= 1'b0;
                primed      <= 1'b1;
            end
        end
    end

endmodule
